gps_sample_sched: RTL and testbench

//  Sequences the GPS-to-MCU SPI bridge. Synchronises the front-end sample clock and I/Q bits into the MCU_CLK_25_000 domain.

---
 rtl/gps_bridge_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 31 +++
 rtl/gps_sample_sched.sv | 192 +++++++++++++++++++
 tb/tb_gps_sample_sched.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/gps_bridge_pkg.sv
// Shared definitions for the GPS-to-MCU SPI bridge.
//  - sched_state_t : sample scheduler states (sequential encoding)
//  - gps_sel_t     : bridge select codes for the i0/i1/q0/q1 sample bits
//  - DECIM_W       : width of the decimation ratio input
package gps_bridge_pkg;

    localparam int DECIM_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_REQ   = 2'd2,
        ST_XFER  = 2'd3
    } sched_state_t;

    typedef enum logic [1:0] {
        SEL_I0 = 2'd0,
        SEL_I1 = 2'd1,
        SEL_Q0 = 2'd2,
        SEL_Q1 = 2'd3
    } gps_sel_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit flop-chain synchroniser into the clk domain.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears the chain
//   d     - asynchronous input
//   q     - synchronised output (STAGES clocks of latency)
module sync_2ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/gps_sample_sched.sv
// GPS sample scheduler: synchronises the front-end sample clock and I/Q bits,
// decimates the sample stream, latches one sample and runs the DATAREADY
// handshake with the SPI bridge. Counts dropped samples and ack timeouts.
// Ports:
//   MCU_CLK_25_000 - sole clock, rising edge
//   RESET_N        - asynchronous active-low reset
//   GPS_CLK        - asynchronous front-end sample clock
//   GPS_I0/I1/Q0/Q1- asynchronous sample bits, valid around GPS_CLK rise
//   ENABLE         - run/stop for scheduling
//   DECIM          - forward 1 of every DECIM+1 sample edges
//   STAT_CLR       - one-cycle pulse clearing OVERRUN, ACK_ERR, OVR_CNT
//   BRIDGE_SS      - bridge slave select, low = transfer accepted
//   DATAREADY      - request to the bridge
//   S_I0/I1/Q0/Q1  - latched sample, held for the whole transfer
//   OVERRUN        - sticky, a forwarded sample was dropped
//   ACK_ERR        - sticky, DATAREADY timed out
//   OVR_CNT        - saturating dropped-sample count
module gps_sample_sched
    import gps_bridge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int XFER_CYCLES = 5,
    parameter int ACK_TIMEOUT = 8,
    parameter int OVR_W       = 8
) (
    input  logic               MCU_CLK_25_000,
    input  logic               RESET_N,
    input  logic               GPS_CLK,
    input  logic               GPS_I0,
    input  logic               GPS_I1,
    input  logic               GPS_Q0,
    input  logic               GPS_Q1,
    input  logic               ENABLE,
    input  logic [DECIM_W-1:0] DECIM,
    input  logic               STAT_CLR,
    input  logic               BRIDGE_SS,
    output logic               DATAREADY,
    output logic               S_I0,
    output logic               S_I1,
    output logic               S_Q0,
    output logic               S_Q1,
    output logic               OVERRUN,
    output logic               ACK_ERR,
    output logic [OVR_W-1:0]   OVR_CNT
);

    localparam int XW = $clog2(XFER_CYCLES + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [XW-1:0] XFER_LOAD = XW'(XFER_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(ACK_TIMEOUT - 1);

    // clock and data share the same sync depth so the sample lines up with the event
    logic       w_gclk_s;
    logic [3:0] w_iq_s;
    logic [4:0] w_sync_d;
    logic [4:0] w_sync_q;

    assign w_sync_d = {GPS_CLK, GPS_I0, GPS_I1, GPS_Q0, GPS_Q1};
    assign w_gclk_s = w_sync_q[4];
    assign w_iq_s   = w_sync_q[3:0];

    for (genvar g = 0; g < 5; g++) begin : g_sync
        sync_2ff #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (MCU_CLK_25_000),
            .rst_n (RESET_N),
            .d     (w_sync_d[g]),
            .q     (w_sync_q[g])
        );
    end

    sched_state_t       r_state, w_state_nxt;
    logic               r_gclk_d;
    logic [DECIM_W-1:0] r_dcnt, w_dcnt_nxt;
    logic [XW-1:0]      r_xcnt, w_xcnt_nxt;
    logic [TW-1:0]      r_tcnt, w_tcnt_nxt;
    logic               r_dr, w_dr_nxt;
    logic [3:0]         r_s, w_s_nxt;
    logic               r_ovr, w_ovr_nxt;
    logic               r_ackerr, w_ackerr_nxt;
    logic [OVR_W-1:0]   r_ovr_cnt, w_ovr_cnt_nxt;

    logic w_evt, w_fwd, w_drop;

    always_ff @(posedge MCU_CLK_25_000 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= ST_IDLE;
            r_gclk_d  <= 1'b0;
            r_dcnt    <= '0;
            r_xcnt    <= '0;
            r_tcnt    <= '0;
            r_dr      <= 1'b0;
            r_s       <= '0;
            r_ovr     <= 1'b0;
            r_ackerr  <= 1'b0;
            r_ovr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gclk_d  <= w_gclk_s;
            r_dcnt    <= w_dcnt_nxt;
            r_xcnt    <= w_xcnt_nxt;
            r_tcnt    <= w_tcnt_nxt;
            r_dr      <= w_dr_nxt;
            r_s       <= w_s_nxt;
            r_ovr     <= w_ovr_nxt;
            r_ackerr  <= w_ackerr_nxt;
            r_ovr_cnt <= w_ovr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_dcnt_nxt    = r_dcnt;
        w_xcnt_nxt    = r_xcnt;
        w_tcnt_nxt    = r_tcnt;
        w_dr_nxt      = r_dr;
        w_s_nxt       = r_s;
        w_ovr_nxt     = STAT_CLR ? 1'b0 : r_ovr;
        w_ackerr_nxt  = STAT_CLR ? 1'b0 : r_ackerr;
        w_ovr_cnt_nxt = STAT_CLR ? '0 : r_ovr_cnt;

        w_evt  = w_gclk_s & ~r_gclk_d;
        // >= rather than == so a DECIM reduced below dcnt forwards the next event
        w_fwd  = w_evt && (r_state != ST_IDLE) && (r_dcnt >= DECIM);
        w_drop = w_fwd && ((r_state == ST_REQ) || (r_state == ST_XFER));

        if (w_evt && (r_state != ST_IDLE)) begin
            w_dcnt_nxt = w_fwd ? '0 : r_dcnt + 1'b1;
        end

        // clear is applied above, so a coincident drop still lands as a count of 1
        if (w_drop) begin
            w_ovr_nxt = 1'b1;
            if (w_ovr_cnt_nxt != '1) begin
                w_ovr_cnt_nxt = w_ovr_cnt_nxt + 1'b1;
            end
        end

        case (r_state)
            ST_IDLE: begin
                w_dr_nxt   = 1'b0;
                w_dcnt_nxt = '0;
                if (ENABLE) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_fwd) begin
                    w_s_nxt     = w_iq_s;
                    w_dr_nxt    = 1'b1;
                    w_tcnt_nxt  = '0;
                    w_state_nxt = ST_REQ;
                end else if (!ENABLE) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!BRIDGE_SS) begin
                    w_dr_nxt    = 1'b0;
                    w_xcnt_nxt  = XFER_LOAD;
                    w_state_nxt = ST_XFER;
                end else if (r_tcnt == TO_LAST) begin
                    w_dr_nxt     = 1'b0;
                    w_ackerr_nxt = 1'b1;
                    w_state_nxt  = ENABLE ? ST_ARMED : ST_IDLE;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end
            ST_XFER: begin
                if (r_xcnt == '0) begin
                    w_state_nxt = ENABLE ? ST_ARMED : ST_IDLE;
                end else begin
                    w_xcnt_nxt = r_xcnt - 1'b1;
                end
            end
            default: begin
                w_dr_nxt    = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign DATAREADY = r_dr;
    assign S_I0      = r_s[3];
    assign S_I1      = r_s[2];
    assign S_Q0      = r_s[1];
    assign S_Q1      = r_s[0];
    assign OVERRUN   = r_ovr;
    assign ACK_ERR   = r_ackerr;
    assign OVR_CNT   = r_ovr_cnt;

endmodule

// File: tb/tb_gps_sample_sched.sv
// Directed bench for gps_sample_sched. Inputs change on the falling clock
// edge, outputs are sampled on the falling edge (or #1 after an async event).
module tb_gps_sample_sched;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       gps_clk = 1'b0, i0 = 1'b0, i1 = 1'b0, q0 = 1'b0, q1 = 1'b0;
    logic       en = 1'b0, clr = 1'b0, ss = 1'b1;
    logic [3:0] decim = 4'd0;
    logic       dr, si0, si1, sq0, sq1, ovr, ack_err;
    logic [7:0] ovr_cnt;

    int         n_cmp = 0, n_bad = 0;
    int         dr_cnt = 0;
    logic [3:0] last_s = 4'd0;
    logic       dr_q = 1'b0;
    bit         auto_ss = 1'b0;
    logic [3:0] pat [4] = '{4'b1010, 4'b0101, 4'b1111, 4'b0000};

    gps_sample_sched dut (
        .MCU_CLK_25_000 (clk),
        .RESET_N        (rst_n),
        .GPS_CLK        (gps_clk),
        .GPS_I0         (i0),
        .GPS_I1         (i1),
        .GPS_Q0         (q0),
        .GPS_Q1         (q1),
        .ENABLE         (en),
        .DECIM          (decim),
        .STAT_CLR       (clr),
        .BRIDGE_SS      (ss),
        .DATAREADY      (dr),
        .S_I0           (si0),
        .S_I1           (si1),
        .S_Q0           (sq0),
        .S_Q1           (sq1),
        .OVERRUN        (ovr),
        .ACK_ERR        (ack_err),
        .OVR_CNT        (ovr_cnt)
    );

    always #20 clk = ~clk;

    // count DATAREADY pulses and capture the sample presented with each
    always @(negedge clk) begin
        if (dr && !dr_q) begin
            dr_cnt <= dr_cnt + 1;
            last_s <= {si0, si1, sq0, sq1};
        end
        dr_q <= dr;
    end

    // bridge model: select goes low the half-cycle after DATAREADY is seen
    initial begin
        forever begin
            @(negedge clk);
            if (auto_ss) ss = ~dr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // one sample-clock period; must be called right after a falling clk edge
    task automatic gps_edge(input logic [3:0] iq, input int hi, input int lo);
        {i0, i1, q0, q1} = iq;
        gps_clk = 1'b1;
        repeat (hi) @(negedge clk);
        gps_clk = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        int base, cnt;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_dr", dr, 1'b0);
        chk("rst_s", {si0, si1, sq0, sq1}, 4'b0000);
        chk("rst_ovr", ovr, 1'b0);
        chk("rst_ackerr", ack_err, 1'b0);
        chk("rst_ovrcnt", ovr_cnt, 8'd0);
        rst_n = 1'b1;
        en = 1'b1;
        auto_ss = 1'b1;
        repeat (2) @(negedge clk);

        // DECIM=0, slow sample clock: every edge requested, sample matches pins
        for (int k = 0; k < 4; k++) begin
            base = dr_cnt;
            gps_edge(pat[k], 4, 4);
            chk("d0_dr", dr_cnt, base + 1);
            chk("d0_s", last_s, pat[k]);
        end
        chk("d0_ovrcnt", ovr_cnt, 8'd0);

        // DECIM=3: pulses on edges 4, 8, 12, 16
        decim = 4'd3;
        base = dr_cnt;
        for (int e = 1; e <= 16; e++) begin
            gps_edge(pat[e % 4], 4, 4);
            chk("d3_dr", dr_cnt, base + e / 4);
        end

        // fast sample clock: 1 accepted, 3 dropped per 4 events
        decim = 4'd0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        base = dr_cnt;
        for (int e = 0; e < 8; e++) gps_edge(pat[e % 4], 1, 1);
        repeat (4) @(negedge clk);
        chk("fast_dr", dr_cnt, base + 2);
        chk("fast_ovrcnt", ovr_cnt, 8'd6);
        chk("fast_ovr", ovr, 1'b1);

        // saturation
        for (int e = 0; e < 400; e++) gps_edge(pat[e % 4], 1, 1);
        repeat (10) @(negedge clk);
        chk("sat_ovrcnt", ovr_cnt, 8'd255);

        // clear coincident with a drop: clear first, then count it
        gps_edge(4'b1001, 1, 1);
        gps_edge(4'b0110, 1, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("clrdrop_ovrcnt", ovr_cnt, 8'd1);
        chk("clrdrop_ovr", ovr, 1'b1);
        chk("clrdrop_s", {si0, si1, sq0, sq1}, 4'b1001);

        // no acknowledge: DATAREADY high exactly 8 cycles, then ACK_ERR
        repeat (8) @(negedge clk);
        auto_ss = 1'b0;
        ss = 1'b1;
        gps_edge(4'b1100, 1, 1);
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (dr) cnt++;
        end
        chk("to_len", cnt, 8);
        chk("to_ackerr", ack_err, 1'b1);
        chk("to_dr", dr, 1'b0);
        chk("to_s", {si0, si1, sq0, sq1}, 4'b1100);

        // after timeout the next event is served normally
        auto_ss = 1'b1;
        base = dr_cnt;
        gps_edge(4'b0011, 4, 4);
        chk("post_to_dr", dr_cnt, base + 1);
        chk("post_to_s", last_s, 4'b0011);
        chk("post_to_ackerr", ack_err, 1'b1);

        // clear alone
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        chk("clr_ovrcnt", ovr_cnt, 8'd0);
        chk("clr_ovr", ovr, 1'b0);
        chk("clr_ackerr", ack_err, 1'b0);

        // disabled: events ignored, no overruns
        en = 1'b0;
        repeat (8) @(negedge clk);
        base = dr_cnt;
        gps_edge(4'b1111, 1, 1);
        gps_edge(4'b1111, 1, 1);
        repeat (4) @(negedge clk);
        chk("dis_dr", dr_cnt, base);
        chk("dis_ovrcnt", ovr_cnt, 8'd0);
        chk("dis_s", {si0, si1, sq0, sq1}, 4'b0011);
        en = 1'b1;
        repeat (2) @(negedge clk);

        // async reset mid-transfer
        gps_edge(4'b1111, 1, 1);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_s", {si0, si1, sq0, sq1}, 4'b1111);
        rst_n = 1'b0;
        #1;
        chk("arst_dr", dr, 1'b0);
        chk("arst_s", {si0, si1, sq0, sq1}, 4'b0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = dr_cnt;
        gps_edge(4'b0101, 4, 4);
        chk("post_rst_dr", dr_cnt, base + 1);
        chk("post_rst_s", last_s, 4'b0101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
